hyperbus_trx_sched: RTL and testbench

Transaction scheduler in front of the HyperBus PHY command path and the write upsizer. It arbitrates AXI AW and AR requests round-robin and converts the winner into one PHY transfer command. It pulses the write-datapath handshake (start offset, size, len) and holds the PHY until the transfer completes. Write responses (B) and read-id tagging are generated here. Exactly one transfer is in flight at a time.

---
 rtl/hyperbus_pkg.sv | 40 ++++
 rtl/hyperbus_rr_arb2.sv | 32 +++
 rtl/hyperbus_trx_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_hyperbus_trx_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared types and constants for the HyperBus transaction
// scheduler.
//   - sched_state_e : scheduler FSM states
//   - hyper_tf_t    : latched transfer descriptor (dir, addr, len, size, id,
//                     PHY beat count). Field widths follow the HB_* constants
//                     below, which are also the scheduler's parameter defaults.
//   - phy_bytes()   : bytes moved per PHY beat (two bytes per PHY)
//   - AXI_RESP_*    : AXI B response codes
package hyperbus_pkg;

  localparam int unsigned HB_ADDR_W = 48;
  localparam int unsigned HB_ID_W   = 6;
  localparam int unsigned HB_LEN_W  = 8;
  localparam int unsigned HB_PLEN_W = 16;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_WR = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_RESP    = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic                 write;
    logic [HB_ADDR_W-1:0] addr;
    logic [HB_LEN_W-1:0]  len;
    logic [2:0]           size;
    logic [HB_ID_W-1:0]   id;
    logic [HB_PLEN_W-1:0] plen;
  } hyper_tf_t;

  function automatic int unsigned phy_bytes(input int unsigned num_phys);
    return 2 * num_phys;
  endfunction

endpackage

// File: rtl/hyperbus_rr_arb2.sv
// hyperbus_rr_arb2: two-requester round-robin arbiter.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[1:0]    : requests (bit 0 = AW, bit 1 = AR)
//   hs_i          : a granted request was accepted this cycle
//   grant_o[1:0]  : one-hot grant (combinational)
// With both requesting, the side not granted last wins. The pointer only
// moves when a grant is actually consumed (hs_i); reset favours bit 0.
module hyperbus_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       hs_i,
  output logic [1:0] grant_o
);

  logic prefer_ar_q, prefer_ar_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = prefer_ar_q ? 2'b10 : 2'b01;
    prefer_ar_d = prefer_ar_q;
    // after an AW grant favour AR next, and vice versa
    if (hs_i) prefer_ar_d = grant_o[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prefer_ar_q <= 1'b0;
    else         prefer_ar_q <= prefer_ar_d;
  end

endmodule

// File: rtl/hyperbus_trx_sched.sv
// hyperbus_trx_sched: arbitrates AXI AW/AR round-robin and turns the winner
// into a single HyperBus PHY transfer command; one transfer in flight.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   aw_* / ar_*                   : AXI address channels (ready only in Idle)
//   trx_valid_o/ready_i, trx_*    : PHY command (addr, dir, beats-1)
//   trans_handshake_o             : PHY command accepted
//   is_a_write_o, start_addr_o,
//   size_o, len_o                 : write-upsizer info for current transfer
//   w_done_i / r_done_i           : transfer completion strobes
//   r_id_o                        : R id while waiting on a read
//   b_valid_o/ready_i, b_id_o,
//   b_resp_o                      : AXI write response
//   busy_o                        : scheduler not Idle
// Optional: HYPERBUS_TRX_SCHED_TIMEOUT_EN adds a watchdog of TimeoutCycles
// cycles on the wait states and the extra output timeout_o.
module hyperbus_trx_sched
  import hyperbus_pkg::*;
#(
  parameter int unsigned AxiAddrWidth  = HB_ADDR_W,
  parameter int unsigned AxiIdWidth    = HB_ID_W,
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned NumPhys       = 2,
  parameter int unsigned BurstLength   = HB_LEN_W,
  parameter int unsigned PhyLenWidth   = HB_PLEN_W,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned OffW         = $clog2(AxiDataWidth/8)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic [BurstLength-1:0]  aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [BurstLength-1:0]  ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  output logic                    trx_valid_o,
  input  logic                    trx_ready_i,
  output logic                    trx_write_o,
  output logic [AxiAddrWidth-1:0] trx_addr_o,
  output logic [PhyLenWidth-1:0]  trx_plen_o,
  output logic                    trans_handshake_o,
  output logic                    is_a_write_o,
  output logic [OffW-1:0]         start_addr_o,
  output logic [2:0]              size_o,
  output logic [BurstLength-1:0]  len_o,
  input  logic                    w_done_i,
  input  logic                    r_done_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    busy_o
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
  ,
  output logic                    timeout_o
`endif
);

  localparam int unsigned PhyBytes = phy_bytes(NumPhys);
  localparam int unsigned PhyOffW  = $clog2(PhyBytes);

  sched_state_e state_q, state_d;
  hyper_tf_t    tf_q, tf_d, sel_tf;

  logic [1:0] req, grant;
  logic       acc_hs;

  logic [AxiAddrWidth-1:0] sel_addr;
  logic [BurstLength-1:0]  sel_len;
  logic [2:0]              sel_size;
  logic [31:0]             total_bytes;

  // ---------------------------------------------------------------- arbiter
  assign req = {ar_valid_i, aw_valid_i} & {2{state_q == ST_IDLE}};

  hyperbus_rr_arb2 i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req),
    .hs_i    (acc_hs),
    .grant_o (grant)
  );

  assign aw_ready_o = grant[0];
  assign ar_ready_o = grant[1];
  assign acc_hs     = (aw_valid_i & aw_ready_o) | (ar_valid_i & ar_ready_o);

  // ------------------------------------------------- descriptor of winner
  always_comb begin
    sel_addr = grant[1] ? ar_addr_i : aw_addr_i;
    sel_len  = grant[1] ? ar_len_i  : aw_len_i;
    sel_size = grant[1] ? ar_size_i : aw_size_i;
    // bytes touched from the start of the first PHY beat; the PHY beat
    // count is ceil(total/PhyBytes)-1, which equals (total-1)>>PhyOffW
    // since total is always >= 1
    total_bytes = 32'(sel_addr[PhyOffW-1:0])
                + ((32'(sel_len) + 32'd1) << sel_size);
    sel_tf       = '0;
    sel_tf.write = grant[0];
    sel_tf.addr  = sel_addr;
    sel_tf.len   = sel_len;
    sel_tf.size  = sel_size;
    sel_tf.id    = grant[1] ? ar_id_i : aw_id_i;
    sel_tf.plen  = PhyLenWidth'((total_bytes - 32'd1) >> PhyOffW);
  end

  // ---------------------------------------------------------------- watchdog
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            slverr_q, slverr_d;
  logic            timeout_q, timeout_d;
  logic            in_wait, to_hit;

  assign in_wait = (state_q == ST_WAIT_WR) || (state_q == ST_WAIT_RD);
  assign to_hit  = in_wait && (cnt_q == CntW'(TimeoutCycles - 1));
  // held at zero outside the wait states, so it starts from 0 on entry
  assign cnt_d   = in_wait ? cnt_q + CntW'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  // --------------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    tf_d    = tf_q;
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
    slverr_d  = slverr_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (acc_hs) begin
          tf_d    = sel_tf;
          state_d = ST_ISSUE;
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
          slverr_d = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        if (trx_ready_i) state_d = tf_q.write ? ST_WAIT_WR : ST_WAIT_RD;
      end
      ST_WAIT_WR: begin
        if (w_done_i) state_d = ST_RESP;
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
        else if (to_hit) begin
          state_d  = ST_RESP;
          slverr_d = 1'b1;
        end
`endif
      end
      ST_WAIT_RD: begin
        if (r_done_i) state_d = ST_IDLE;
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
        else if (to_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (b_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tf_q    <= '0;
    end else begin
      state_q <= state_d;
      tf_q    <= tf_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign trx_valid_o       = (state_q == ST_ISSUE);
  assign trx_write_o       = tf_q.write;
  assign trx_addr_o        = tf_q.addr;
  assign trx_plen_o        = tf_q.plen;
  assign trans_handshake_o = trx_valid_o & trx_ready_i;
  assign is_a_write_o      = tf_q.write;
  assign start_addr_o      = tf_q.addr[OffW-1:0];
  assign size_o            = tf_q.size;
  assign len_o             = tf_q.len;
  assign r_id_o            = tf_q.id;
  assign b_valid_o         = (state_q == ST_RESP);
  assign b_id_o            = tf_q.id;
  assign busy_o            = (state_q != ST_IDLE);
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
  assign b_resp_o = (b_valid_o && slverr_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
  assign b_resp_o = AXI_RESP_OKAY;
`endif

endmodule

// File: tb/tb_hyperbus_trx_sched.sv
module tb_hyperbus_trx_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aw_valid_i = 1'b0, ar_valid_i = 1'b0;
  logic        aw_ready_o, ar_ready_o;
  logic [47:0] aw_addr_i = '0, ar_addr_i = '0;
  logic [7:0]  aw_len_i = '0, ar_len_i = '0;
  logic [2:0]  aw_size_i = '0, ar_size_i = '0;
  logic [5:0]  aw_id_i = '0, ar_id_i = '0;
  logic        trx_valid_o, trx_ready_i = 1'b0, trx_write_o;
  logic [47:0] trx_addr_o;
  logic [15:0] trx_plen_o;
  logic        trans_handshake_o, is_a_write_o;
  logic [2:0]  start_addr_o;
  logic [2:0]  size_o;
  logic [7:0]  len_o;
  logic        w_done_i = 1'b0, r_done_i = 1'b0;
  logic [5:0]  r_id_o, b_id_o;
  logic        b_valid_o, b_ready_i = 1'b0;
  logic [1:0]  b_resp_o;
  logic        busy_o;
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
  logic        timeout_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hyperbus_trx_sched #(.TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_id_i(aw_id_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_id_i(ar_id_i),
    .trx_valid_o(trx_valid_o), .trx_ready_i(trx_ready_i), .trx_write_o(trx_write_o),
    .trx_addr_o(trx_addr_o), .trx_plen_o(trx_plen_o),
    .trans_handshake_o(trans_handshake_o), .is_a_write_o(is_a_write_o),
    .start_addr_o(start_addr_o), .size_o(size_o), .len_o(len_o),
    .w_done_i(w_done_i), .r_done_i(r_done_i), .r_id_o(r_id_o),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .b_resp_o(b_resp_o), .busy_o(busy_o)
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cyc(); cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    checks++;
    if ({trx_valid_o, aw_ready_o, ar_ready_o, b_valid_o, busy_o, b_resp_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {trx_valid_o, aw_ready_o, ar_ready_o, b_valid_o, busy_o, b_resp_o});
    end
    checks++;
    if ({trx_addr_o, trx_plen_o, len_o, size_o, b_id_o} !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {trx_addr_o, trx_plen_o, len_o, size_o, b_id_o});
    end
    do_reset();
  endtask

  task automatic test_single_write();
    aw_valid_i = 1'b1; aw_addr_i = 48'h1002; aw_len_i = 8'd3; aw_size_i = 3'd1; aw_id_i = 6'd5;
    #1;
    checks++;
    if ({aw_ready_o, ar_ready_o} !== 2'b10) begin
      errors++; $display("FAIL wr_aw_ready got %b exp 10", {aw_ready_o, ar_ready_o});
    end
    cyc();
    aw_valid_i = 1'b0;
    checks++;
    if ({trx_valid_o, trx_write_o, is_a_write_o, busy_o} !== 4'b1111) begin
      errors++; $display("FAIL wr_issue got %b exp 1111", {trx_valid_o, trx_write_o, is_a_write_o, busy_o});
    end
    checks++;
    if (trx_addr_o !== 48'h1002 || trx_plen_o !== 16'd2) begin
      errors++; $display("FAIL wr_cmd got addr %h plen %0d exp 1002 2", trx_addr_o, trx_plen_o);
    end
    checks++;
    if (start_addr_o !== 3'd2 || size_o !== 3'd1 || len_o !== 8'd3) begin
      errors++; $display("FAIL wr_upsz got %0d %0d %0d exp 2 1 3", start_addr_o, size_o, len_o);
    end
    trx_ready_i = 1'b1;
    #1;
    checks++;
    if (trans_handshake_o !== 1'b1) begin
      errors++; $display("FAIL wr_trans_hs got %b exp 1", trans_handshake_o);
    end
    cyc();
    trx_ready_i = 1'b0;
    checks++;
    if (trx_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin
      errors++; $display("FAIL wr_wait got %b%b exp 00", trx_valid_o, b_valid_o);
    end
    w_done_i = 1'b1;
    cyc();
    w_done_i = 1'b0;
    checks++;
    if (b_valid_o !== 1'b1 || b_id_o !== 6'd5 || b_resp_o !== 2'b00) begin
      errors++; $display("FAIL wr_b got v%b id%0d r%0d exp v1 id5 r0", b_valid_o, b_id_o, b_resp_o);
    end
    b_ready_i = 1'b1;
    cyc();
    b_ready_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || b_valid_o !== 1'b0) begin
      errors++; $display("FAIL wr_idle got %b%b exp 00", busy_o, b_valid_o);
    end
  endtask

  task automatic test_round_robin();
    bit exp_wr;
    do_reset();
    aw_valid_i = 1'b1; aw_addr_i = 48'h100; aw_len_i = 8'd0; aw_size_i = 3'd2; aw_id_i = 6'd1;
    ar_valid_i = 1'b1; ar_addr_i = 48'h200; ar_len_i = 8'd0; ar_size_i = 3'd2; ar_id_i = 6'd2;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2 == 0);
      #1;
      checks++;
      if ({aw_ready_o, ar_ready_o} !== {exp_wr, !exp_wr}) begin
        errors++; $display("FAIL rr_grant%0d got %b exp %b", i, {aw_ready_o, ar_ready_o}, {exp_wr, !exp_wr});
      end
      cyc();
      checks++;
      if (trx_write_o !== exp_wr || trx_addr_o !== (exp_wr ? 48'h100 : 48'h200) || aw_ready_o !== 1'b0) begin
        errors++; $display("FAIL rr_issue%0d got w%b a%h rdy%b exp w%b", i, trx_write_o, trx_addr_o, aw_ready_o, exp_wr);
      end
      trx_ready_i = 1'b1;
      cyc();
      trx_ready_i = 1'b0;
      if (exp_wr) begin
        w_done_i = 1'b1; cyc(); w_done_i = 1'b0;
        b_ready_i = 1'b1; cyc(); b_ready_i = 1'b0;
      end else begin
        checks++;
        if (r_id_o !== 6'd2) begin
          errors++; $display("FAIL rr_rid%0d got %0d exp 2", i, r_id_o);
        end
        r_done_i = 1'b1; cyc(); r_done_i = 1'b0;
      end
    end
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
  endtask

  task automatic test_read();
    ar_valid_i = 1'b1; ar_addr_i = 48'h0; ar_len_i = 8'd7; ar_size_i = 3'd3; ar_id_i = 6'd9;
    #1;
    checks++;
    if (ar_ready_o !== 1'b1) begin
      errors++; $display("FAIL rd_ar_ready got %b exp 1", ar_ready_o);
    end
    cyc();
    ar_valid_i = 1'b0;
    checks++;
    if (trx_valid_o !== 1'b1 || trx_write_o !== 1'b0 || trx_plen_o !== 16'd15) begin
      errors++; $display("FAIL rd_issue got v%b w%b plen %0d exp v1 w0 15", trx_valid_o, trx_write_o, trx_plen_o);
    end
    trx_ready_i = 1'b1;
    cyc();
    trx_ready_i = 1'b0;
    checks++;
    if (r_id_o !== 6'd9 || b_valid_o !== 1'b0) begin
      errors++; $display("FAIL rd_wait got id %0d b %b exp 9 0", r_id_o, b_valid_o);
    end
    r_done_i = 1'b1;
    cyc();
    r_done_i = 1'b0;
    ar_valid_i = 1'b1; ar_addr_i = 48'h80; ar_len_i = 8'd1; ar_size_i = 3'd2; ar_id_i = 6'd4;
    #1;
    checks++;
    if (busy_o !== 1'b0 || b_valid_o !== 1'b0 || ar_ready_o !== 1'b1) begin
      errors++; $display("FAIL rd_done got busy %b b %b ar_rdy %b exp 0 0 1", busy_o, b_valid_o, ar_ready_o);
    end
    cyc();
    ar_valid_i = 1'b0;
    // 0 + 2*4 = 8 bytes -> 2 beats
    checks++;
    if (trx_addr_o !== 48'h80 || trx_plen_o !== 16'd1) begin
      errors++; $display("FAIL rd_b2b got addr %h plen %0d exp 80 1", trx_addr_o, trx_plen_o);
    end
    trx_ready_i = 1'b1; cyc(); trx_ready_i = 1'b0;
    r_done_i = 1'b1; cyc(); r_done_i = 1'b0;
  endtask

  task automatic test_stall_and_reset();
    int bad;
    aw_valid_i = 1'b1; aw_addr_i = 48'h20; aw_len_i = 8'd0; aw_size_i = 3'd2; aw_id_i = 6'd3;
    cyc();
    // next AW pending while the first is stalled
    aw_addr_i = 48'h40; aw_len_i = 8'd1; aw_size_i = 3'd3; aw_id_i = 6'd7;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (trx_valid_o !== 1'b1 || trx_addr_o !== 48'h20 || trx_plen_o !== 16'd0 ||
          aw_ready_o !== 1'b0 || b_id_o !== 6'd3) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stall_stable got %0d bad cycles exp 0", bad);
    end
    trx_ready_i = 1'b1; cyc(); trx_ready_i = 1'b0;
    w_done_i = 1'b1; cyc(); w_done_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (b_valid_o !== 1'b1 || aw_ready_o !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bstall got %0d bad cycles exp 0", bad);
    end
    b_ready_i = 1'b1;
    #1;
    checks++;
    if (aw_ready_o !== 1'b0) begin
      errors++; $display("FAIL bhs_aw_ready got %b exp 0", aw_ready_o);
    end
    cyc();
    b_ready_i = 1'b0;
    checks++;
    if (aw_ready_o !== 1'b1) begin
      errors++; $display("FAIL post_b_aw_ready got %b exp 1", aw_ready_o);
    end
    cyc();
    aw_valid_i = 1'b0;
    // 0 + 2*8 = 16 bytes -> 4 beats
    checks++;
    if (trx_addr_o !== 48'h40 || trx_plen_o !== 16'd3 || b_id_o !== 6'd7) begin
      errors++; $display("FAIL b2b_wr got addr %h plen %0d id %0d exp 40 3 7", trx_addr_o, trx_plen_o, b_id_o);
    end
    trx_ready_i = 1'b1; cyc(); trx_ready_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL waitwr_busy got %b exp 1", busy_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, trx_valid_o, b_valid_o, is_a_write_o} !== 4'b0 || trx_addr_o !== '0 || len_o !== '0) begin
      errors++; $display("FAIL mid_reset got %b addr %h len %0d exp 0", {busy_o, trx_valid_o, b_valid_o, is_a_write_o}, trx_addr_o, len_o);
    end
    cyc();
    rst_ni = 1'b1;
    w_done_i = 1'b1; cyc(); w_done_i = 1'b0;
    cyc();
    checks++;
    if (b_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL stray_wdone got b %b busy %b exp 0 0", b_valid_o, busy_o);
    end
  endtask

`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    aw_valid_i = 1'b1; aw_addr_i = 48'h0; aw_len_i = 8'd0; aw_size_i = 3'd2; aw_id_i = 6'd11;
    cyc();
    aw_valid_i = 1'b0;
    trx_ready_i = 1'b1; cyc(); trx_ready_i = 1'b0;
    n = 0;
    while (b_valid_o !== 1'b1 && n < 40) begin
      cyc(); n++;
    end
    checks++;
    if (n !== 16 || b_resp_o !== 2'b10 || b_id_o !== 6'd11) begin
      errors++; $display("FAIL timeout_wr got %0d cycles resp %0d exp 16 2", n, b_resp_o);
    end
    b_ready_i = 1'b1; cyc(); b_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_stall_and_reset();
`ifdef HYPERBUS_TRX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
